// File: rtl/atm_pager_quad_if.sv
// Z80-side bus bundle for the four-window ATM pager: decode inputs, config port
// write strobe, and the page/stall outputs toward the DRAM/ROM arbiter.
interface atm_pager_quad_if #(parameter int PAGE_W = 8);
    logic              zpos;
    logic              zneg;
    logic [15:0]       za;
    logic [7:0]        zd;
    logic              mreq_n;
    logic              m1_n;
    logic              pager_off;
    logic              pent1m_ROM;
    logic [5:0]        pent1m_page;
    logic              pent1m_ram0_0;
    logic              pent1m_1m_on;
    logic              atm_xxF7_wr;
    logic [PAGE_W-1:0] ext_hi;
    logic              dos;
    logic              dos_turn_on;
    logic              dos_turn_off;
    logic              zclk_stall;
    logic [PAGE_W-1:0] page;
    logic              romnram;
    logic [7:0]        cfg_rd;

    modport master (
        output zpos, zneg, za, zd, mreq_n, m1_n, pager_off, pent1m_ROM,
               pent1m_page, pent1m_ram0_0, pent1m_1m_on, atm_xxF7_wr, ext_hi, dos,
        input  dos_turn_on, dos_turn_off, zclk_stall, page, romnram, cfg_rd
    );

    modport slave (
        input  zpos, zneg, za, zd, mreq_n, m1_n, pager_off, pent1m_ROM,
               pent1m_page, pent1m_ram0_0, pent1m_1m_on, atm_xxF7_wr, ext_hi, dos,
        output dos_turn_on, dos_turn_off, zclk_stall, page, romnram, cfg_rd
    );
endinterface

// File: rtl/atm_pager_quad.sv
// ATM pager serving all four 16K Z80 windows, two maps each, with xxF7 config
// read-back and a DOS-entry Z80 clock stall.
//
//  state | meaning
//  IDLE  | Z80 clock free-running
//  STALL | holding Z80 clock after a DOS entry, cnt cycles left
module atm_pager_quad #(
    parameter int          PAGE_W    = 8,
    parameter int          STALL_CYC = 3,
    parameter logic [5:0]  DOS_HI    = 6'h3D
) (
    input  logic              fclk,
    input  logic              rst,
    atm_pager_quad_if.slave   bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] STALL = 1'b1;
    localparam logic [2:0] CNT_LOAD = 3'(STALL_CYC);

    logic [PAGE_W-1:0] pg_r  [4][2];
    logic              ram_r [4][2];
    logic              d7_r  [4][2];

    logic [1:0]        win;
    logic              map;
    logic [PAGE_W-1:0] wr_page;
    logic [PAGE_W-1:0] sel_page;
    logic              sel_ram;
    logic              sel_d7;
    logic [PAGE_W-1:0] nxt_page;
    logic              nxt_rom;
    logic              m1_r;
    logic              mreq_r;
    logic              acc;
    logic              dos_on;
    logic [0:0]        state;
    logic [2:0]        cnt;
    logic              unused_ok;

    assign win = bus.za[15:14];
    assign map = bus.pent1m_ROM;
    assign unused_ok = ^{bus.za[7:0], bus.ext_hi[7:0]};

    always_comb begin
        wr_page       = bus.ext_hi;
        wr_page[7:0]  = ~bus.zd;
        if (bus.za[11])
            wr_page = ~PAGE_W'(bus.zd[5:0]);
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                ram_r[0][k] <= 1'b0;
                d7_r[0][k]  <= 1'b1;
                pg_r[1][k]  <= PAGE_W'(5);
                ram_r[1][k] <= 1'b1;
                d7_r[1][k]  <= 1'b0;
                pg_r[2][k]  <= PAGE_W'(2);
                ram_r[2][k] <= 1'b1;
                d7_r[2][k]  <= 1'b0;
                pg_r[3][k]  <= '0;
                ram_r[3][k] <= 1'b1;
                d7_r[3][k]  <= 1'b1;
            end
            pg_r[0][0] <= ~PAGE_W'(1);
            pg_r[0][1] <= ~PAGE_W'(3);
        end else if (bus.atm_xxF7_wr) begin
            pg_r[win][map]  <= wr_page;
            ram_r[win][map] <= bus.za[11] ? bus.zd[6] : 1'b1;
            if (bus.za[11])
                d7_r[win][map] <= bus.zd[7];
        end
    end

    // d7 substitutes the low page bits with the 7FFD page (RAM) or the DOS flag (ROM)
    always_comb begin
        sel_page = pg_r[win][map];
        sel_ram  = ram_r[win][map];
        sel_d7   = d7_r[win][map];
        nxt_page = sel_page;
        nxt_rom  = ~sel_ram;
        if (sel_d7) begin
            if (sel_ram) begin
                if (bus.pent1m_1m_on)
                    nxt_page[5:0] = bus.pent1m_page;
                else
                    nxt_page[2:0] = bus.pent1m_page[2:0];
            end else begin
                nxt_page[0] = bus.dos;
            end
        end
        if (bus.pager_off) begin
            nxt_rom  = 1'b1;
            nxt_page = '1;
        end else if (bus.pent1m_ram0_0 && win == 2'd0) begin
            nxt_rom  = 1'b0;
            nxt_page = '0;
        end
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            bus.page    <= '0;
            bus.romnram <= 1'b1;
            bus.cfg_rd  <= '0;
        end else begin
            bus.page    <= nxt_page;
            bus.romnram <= nxt_rom;
            bus.cfg_rd  <= {sel_d7, sel_ram, ~sel_page[5:0]};
        end
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            m1_r   <= 1'b1;
            mreq_r <= 1'b1;
        end else begin
            if (bus.zpos)
                m1_r <= bus.m1_n;
            if (bus.zneg)
                mreq_r <= bus.mreq_n;
        end
    end

    assign acc    = bus.zneg & ~m1_r & ~bus.mreq_n & mreq_r;
    assign dos_on = acc & (bus.za[13:8] == DOS_HI) & bus.pent1m_ROM
                  & d7_r[0][1] & ~ram_r[0][1];
    // DOS entry wins when a RAM window decodes the entry address too
    assign bus.dos_turn_on  = dos_on;
    assign bus.dos_turn_off = acc & ram_r[win][1] & ~dos_on;

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (dos_on) begin
            state <= STALL;
            cnt   <= CNT_LOAD;
        end else if (state == STALL) begin
            cnt <= cnt - 3'd1;
            if (cnt == 3'd1)
                state <= IDLE;
        end
    end

    assign bus.zclk_stall = dos_on | (state == STALL);
endmodule

// File: tb/tb_atm_pager_quad.sv
// Self-checking bench for atm_pager_quad (PAGE_W=10, STALL_CYC=3): config
// writes, page mux, DOS strobes and the Z80 clock stall.
module tb_atm_pager_quad;
    localparam int PW = 10;

    typedef struct packed {
        logic [PW-1:0] page;
        logic          rom;
        logic [7:0]    cfg;
    } exp_t;

    logic fclk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];
    int   stall_q[$];

    atm_pager_quad_if #(.PAGE_W(PW)) bus ();

    atm_pager_quad #(.PAGE_W(PW), .STALL_CYC(3), .DOS_HI(6'h3D)) dut (
        .fclk (fclk),
        .rst  (rst),
        .bus  (bus)
    );

    initial begin
        fclk = 1'b0;
        forever #5 fclk = ~fclk;
    end

    task automatic cyc();
        @(posedge fclk);
        #1;
    endtask

    task automatic set_defaults();
        bus.zpos = 0; bus.zneg = 0; bus.za = 16'h0; bus.zd = 8'h0;
        bus.mreq_n = 1; bus.m1_n = 1; bus.pager_off = 0; bus.pent1m_ROM = 1;
        bus.pent1m_page = 6'h0; bus.pent1m_ram0_0 = 0; bus.pent1m_1m_on = 1;
        bus.atm_xxF7_wr = 0; bus.ext_hi = '0; bus.dos = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        set_defaults();
        cyc();
        cyc();
        rst = 0;
        cyc();
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus.za = a; bus.zd = d; bus.atm_xxF7_wr = 1;
        cyc();
        bus.atm_xxF7_wr = 0;
    endtask

    // drives an M1 opcode fetch; returns in the cycle where acc is asserted
    task automatic m1_fetch(input logic [15:0] a);
        bus.za = a; bus.m1_n = 0; bus.zpos = 1; bus.mreq_n = 1; bus.zneg = 1;
        cyc();
        bus.zpos = 0; bus.mreq_n = 0;
        #1;
    endtask

    task automatic bus_idle();
        bus.m1_n = 1; bus.mreq_n = 1; bus.zpos = 1; bus.zneg = 1;
        cyc();
        bus.zpos = 0; bus.zneg = 0;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [PW-1:0] pg [6] = '{10'h3FC, 10'h005, 10'h002, 10'h000, 10'h3FF, 10'h000};
        logic          rm [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0]    cf [6] = '{8'h83, 8'h7A, 8'h7D, 8'hFF, 8'h81, 8'h81};
        rst = 1;
        set_defaults();
        cyc();
        checks++;
        if (bus.page !== '0 || bus.romnram !== 1'b1 || bus.cfg_rd !== 8'h0 || bus.zclk_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got page %h rom %b cfg %h stall %b, want 000 1 00 0",
                     bus.page, bus.romnram, bus.cfg_rd, bus.zclk_stall);
        end
        rst = 0;
        cyc();
        for (int i = 0; i < 6; i++) begin
            bus.za = {2'(i < 4 ? i : 0), 14'h0};
            bus.pent1m_ROM = (i < 4);
            bus.dos = (i == 4);
            bus.pent1m_ram0_0 = (i == 5);
            sb.push_back('{pg[i], rm[i], cf[i]});
            cyc();
            e = sb.pop_front();
            checks++;
            if (bus.page !== e.page || bus.romnram !== e.rom || bus.cfg_rd !== e.cfg) begin
                errors++;
                $display("FAIL reset_map_%0d: got page %h rom %b cfg %h, want %h %b %h",
                         i, bus.page, bus.romnram, bus.cfg_rd, e.page, e.rom, e.cfg);
            end
        end
        set_defaults();
    endtask

    task automatic test_write_xff7();
        exp_t e;
        bus.pent1m_ROM = 0; bus.pent1m_page = 6'h15;
        // the write cycle itself still sees the old window 0 map 0 config
        sb.push_back('{10'h3FE, 1'b1, 8'h81});
        wr(16'h3FF7, 8'hC1);
        e = sb.pop_front();
        checks++;
        if (bus.page !== e.page || bus.romnram !== e.rom || bus.cfg_rd !== e.cfg) begin
            errors++;
            $display("FAIL xff7_old_value: got page %h rom %b cfg %h, want %h %b %h",
                     bus.page, bus.romnram, bus.cfg_rd, e.page, e.rom, e.cfg);
        end
        for (int i = 0; i < 3; i++) begin
            bus.za = 16'h0000;
            bus.pent1m_1m_on = (i == 0);
            bus.pent1m_ROM = (i == 2);
            if (i == 0)      sb.push_back('{10'h3D5, 1'b0, 8'hC1});
            else if (i == 1) sb.push_back('{10'h3FD, 1'b0, 8'hC1});
            else             sb.push_back('{10'h3FC, 1'b1, 8'h83});
            cyc();
            e = sb.pop_front();
            checks++;
            if (bus.page !== e.page || bus.romnram !== e.rom || bus.cfg_rd !== e.cfg) begin
                errors++;
                $display("FAIL xff7_read_%0d: got page %h rom %b cfg %h, want %h %b %h",
                         i, bus.page, bus.romnram, bus.cfg_rd, e.page, e.rom, e.cfg);
            end
        end
        set_defaults();
    endtask

    task automatic test_write_x7f7();
        exp_t e;
        bus.pent1m_ROM = 0; bus.ext_hi = 10'h300;
        wr(16'hF7F7, 8'h12);
        bus.za = 16'hC000; bus.pent1m_1m_on = 1; bus.pent1m_page = 6'h2D;
        sb.push_back('{10'h3ED, 1'b0, 8'hD2});
        cyc();
        e = sb.pop_front();
        checks++;
        if (bus.page !== e.page || bus.romnram !== e.rom || bus.cfg_rd !== e.cfg) begin
            errors++;
            $display("FAIL x7f7_read: got page %h rom %b cfg %h, want %h %b %h",
                     bus.page, bus.romnram, bus.cfg_rd, e.page, e.rom, e.cfg);
        end
        wr(16'hFFF7, 8'h40);
        bus.za = 16'hC000; bus.pent1m_page = 6'h00;
        sb.push_back('{10'h3FF, 1'b0, 8'h40});
        cyc();
        e = sb.pop_front();
        checks++;
        if (bus.page !== e.page || bus.romnram !== e.rom || bus.cfg_rd !== e.cfg) begin
            errors++;
            $display("FAIL fff7_read: got page %h rom %b cfg %h, want %h %b %h",
                     bus.page, bus.romnram, bus.cfg_rd, e.page, e.rom, e.cfg);
        end
        set_defaults();
    endtask

    task automatic test_dos_on();
        int n;
        for (int pass = 0; pass < 2; pass++) begin
            bus.pent1m_ROM = 1;
            stall_q.push_back(pass == 0 ? 4 : 6);
            n = 0;
            m1_fetch(16'h3D2F);
            checks++;
            if (bus.dos_turn_on !== 1'b1 || bus.dos_turn_off !== 1'b0 || bus.zclk_stall !== 1'b1) begin
                errors++;
                $display("FAIL dos_on_strobe_%0d: got on %b off %b stall %b, want 1 0 1",
                         pass, bus.dos_turn_on, bus.dos_turn_off, bus.zclk_stall);
            end
            n += bus.zclk_stall;
            cyc();
            checks++;
            if (bus.dos_turn_on !== 1'b0) begin
                errors++;
                $display("FAIL dos_on_width_%0d: got on %b, want 0", pass, bus.dos_turn_on);
            end
            if (pass == 1) begin
                bus.mreq_n = 1;
                #1 n += bus.zclk_stall;
                cyc();
                bus.mreq_n = 0;
                #1;
                checks++;
                if (bus.dos_turn_on !== 1'b1) begin
                    errors++;
                    $display("FAIL dos_on_reload: got on %b, want 1", bus.dos_turn_on);
                end
                n += bus.zclk_stall;
                cyc();
            end
            bus.zneg = 0;
            for (int i = 0; i < 20; i++) begin
                n += bus.zclk_stall;
                cyc();
            end
            checks++;
            if (n !== stall_q.pop_front()) begin
                errors++;
                $display("FAIL stall_len_%0d: got %0d cycles, want %0d", pass, n, pass == 0 ? 4 : 6);
            end
            bus_idle();
        end
    endtask

    task automatic test_dos_off();
        bus.pent1m_ROM = 1;
        m1_fetch(16'h8000);
        checks++;
        if (bus.dos_turn_off !== 1'b1 || bus.dos_turn_on !== 1'b0 || bus.zclk_stall !== 1'b0) begin
            errors++;
            $display("FAIL dos_off_strobe: got on %b off %b stall %b, want 0 1 0",
                     bus.dos_turn_on, bus.dos_turn_off, bus.zclk_stall);
        end
        cyc();
        checks++;
        if (bus.dos_turn_off !== 1'b0 || bus.zclk_stall !== 1'b0) begin
            errors++;
            $display("FAIL dos_off_width: got off %b stall %b, want 0 0", bus.dos_turn_off, bus.zclk_stall);
        end
        bus.zneg = 0;
        bus_idle();
        bus.pent1m_ROM = 0;
        m1_fetch(16'h3D00);
        checks++;
        if (bus.dos_turn_on !== 1'b0 || bus.dos_turn_off !== 1'b0 || bus.zclk_stall !== 1'b0) begin
            errors++;
            $display("FAIL dos_map0_none: got on %b off %b stall %b, want 0 0 0",
                     bus.dos_turn_on, bus.dos_turn_off, bus.zclk_stall);
        end
        cyc();
        bus.zneg = 0;
        bus_idle();
        set_defaults();
    endtask

    task automatic test_pager_off();
        exp_t e;
        logic [7:0] cf [8] = '{8'h81, 8'h7A, 8'h7D, 8'hFF, 8'h83, 8'h7A, 8'h7D, 8'hFF};
        bus.pager_off = 1;
        for (int i = 0; i < 8; i++) begin
            bus.za = {2'(i % 4), 14'h1234};
            bus.pent1m_ROM = (i >= 4);
            sb.push_back('{10'h3FF, 1'b1, cf[i]});
            cyc();
            e = sb.pop_front();
            checks++;
            if (bus.page !== e.page || bus.romnram !== e.rom || bus.cfg_rd !== e.cfg) begin
                errors++;
                $display("FAIL pager_off_%0d: got page %h rom %b cfg %h, want %h %b %h",
                         i, bus.page, bus.romnram, bus.cfg_rd, e.page, e.rom, e.cfg);
            end
        end
        set_defaults();
    endtask

    task automatic test_rst_mid_stall();
        exp_t e;
        bus.pent1m_ROM = 0;
        wr(16'h3FF7, 8'hC1);
        bus.pent1m_ROM = 1;
        m1_fetch(16'h3D2F);
        cyc();
        bus.zneg = 0;
        #1;
        checks++;
        if (bus.zclk_stall !== 1'b1) begin
            errors++;
            $display("FAIL mid_stall_active: got stall %b, want 1", bus.zclk_stall);
        end
        rst = 1;
        #1;
        checks++;
        if (bus.zclk_stall !== 1'b0 || bus.page !== '0 || bus.romnram !== 1'b1) begin
            errors++;
            $display("FAIL async_rst: got stall %b page %h rom %b, want 0 000 1",
                     bus.zclk_stall, bus.page, bus.romnram);
        end
        cyc();
        rst = 0;
        set_defaults();
        bus.pent1m_ROM = 0;
        bus.za = 16'h0000;
        sb.push_back('{10'h3FE, 1'b1, 8'h81});
        cyc();
        e = sb.pop_front();
        checks++;
        if (bus.page !== e.page || bus.romnram !== e.rom || bus.cfg_rd !== e.cfg || bus.zclk_stall !== 1'b0) begin
            errors++;
            $display("FAIL rst_defaults: got page %h rom %b cfg %h stall %b, want %h %b %h 0",
                     bus.page, bus.romnram, bus.cfg_rd, bus.zclk_stall, e.page, e.rom, e.cfg);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_xff7();
        test_write_x7f7();
        do_reset();
        test_dos_on();
        test_dos_off();
        test_pager_off();
        test_rst_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
